// File: rtl/cm_pkg.sv
// CM bus protocol bytes and the reply receiver state encoding, shared with
// the guess sequencer.
package cm_pkg;

    localparam logic [7:0] CM_START             = 8'h01;
    localparam logic [7:0] CM_BEGIN_GUESSING    = 8'h02;
    localparam logic [7:0] CM_YES               = 8'h03;
    localparam logic [7:0] CM_NO                = 8'h04;
    localparam logic [7:0] CM_END               = 8'h05;
    localparam logic [7:0] CM_START_GUESS_RANGE = 8'h06;

    typedef enum logic [0:0] {
        RX_IDLE  = 1'b0,
        RX_ARMED = 1'b1
    } rx_state_e;

    // True for the two bytes that terminate a guess frame.
    function automatic logic is_reply(input logic [7:0] b);
        return (b == CM_YES) || (b == CM_NO);
    endfunction

endpackage

// File: rtl/cm_byte_filter.sv
// Receive filter for the CM bus read-back byte: two-stage synchronizer,
// stability counter and last-accepted-byte memory. A byte is accepted once,
// after STABLE_CYC identical synced samples, and only if it differs from the
// previously accepted byte.
module cm_byte_filter
    import cm_pkg::*;
#(
    parameter int STABLE_CYC = 4
) (
    input  logic       CLK_50,
    input  logic       RST_N,
    input  logic [7:0] data_in,
    input  logic       drive_en,
    input  logic       tx_done,
    output logic       acc_valid,
    output logic [7:0] acc_byte
);

    localparam int STAB_W = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYC - 1);

    logic [7:0]        s1_q;
    logic [7:0]        s2_q;
    logic [STAB_W-1:0] stab_q;
    logic [STAB_W-1:0] stab_d;
    logic [7:0]        last_acc_q;
    logic [7:0]        last_acc_d;

    // Acceptance is blocked while the FPGA drives the bus so a filter that is
    // mid-count when drive_en rises never fires.
    always_comb begin
        acc_valid = (stab_q == STAB_MAX) && (s2_q != last_acc_q) && !drive_en;
        acc_byte  = s2_q;
    end

    // Stability count: s1 is the value s2 takes next, so s1 == s2 means the
    // synced byte is about to repeat.
    always_comb begin
        stab_d = stab_q;
        if (drive_en || (s1_q != s2_q)) begin
            stab_d = '0;
        end else if (stab_q != STAB_MAX) begin
            stab_d = stab_q + 1'b1;
        end
    end

    // Forgetting the last byte on a new frame lets an identical reply in the
    // next round be accepted again.
    always_comb begin
        last_acc_d = last_acc_q;
        if (drive_en || tx_done) begin
            last_acc_d = 8'h00;
        end else if (acc_valid) begin
            last_acc_d = s2_q;
        end
    end

    // Synchronizer and filter state registers.
    always_ff @(posedge CLK_50 or negedge RST_N) begin
        if (!RST_N) begin
            s1_q       <= 8'h00;
            s2_q       <= 8'h00;
            stab_q     <= '0;
            last_acc_q <= 8'h00;
        end else begin
            s1_q       <= data_in;
            s2_q       <= s1_q;
            stab_q     <= stab_d;
            last_acc_q <= last_acc_d;
        end
    end

endmodule

// File: rtl/cm_reply_rx.sv
// CM bus reply receiver: decodes filtered MCU reply bytes, times the reply
// latency of each guess frame and keeps the slowest guess seen.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   RX_IDLE  | no frame outstanding; accepted 0x02 gives begin_pulse
//   RX_ARMED | guess frame sent; latency counter runs until YES/NO/timeout
//
// The reported latency includes the filter delay (STABLE_CYC + 1 cycles) on
// top of the true MCU reply delay; it is left in rather than subtracted.
module cm_reply_rx
    import cm_pkg::*;
#(
    parameter int STABLE_CYC  = 4,
    parameter int LAT_W       = 24,
    parameter int TIMEOUT_CYC = 5_000_000
) (
    input  logic             CLK_50,
    input  logic             RST_N,
    input  logic [7:0]       data_in,
    input  logic             drive_en,
    input  logic             tx_done,
    input  logic [7:0]       guess_byte,
    input  logic             clear_stats,
    output logic             begin_pulse,
    output logic             reply_valid,
    output logic             reply_yes,
    output logic [LAT_W-1:0] latency,
    output logic             timeout,
    output logic [LAT_W-1:0] max_latency,
    output logic [7:0]       max_guess,
    output logic             busy
);

    localparam logic [LAT_W-1:0] TIMEOUT_VAL = LAT_W'(TIMEOUT_CYC);
    localparam logic [LAT_W-1:0] LAT_MAX     = '1;

    logic       acc_valid;
    logic [7:0] acc_byte;

    rx_state_e        state_q,     state_d;
    logic [LAT_W-1:0] cnt_q,       cnt_d;
    logic [LAT_W-1:0] cnt_inc;
    logic [7:0]       guess_q,     guess_d;
    logic             begin_q,     begin_d;
    logic             valid_q,     valid_d;
    logic             yes_q,       yes_d;
    logic [LAT_W-1:0] latency_q,   latency_d;
    logic             timeout_q,   timeout_d;
    logic [LAT_W-1:0] max_lat_q,   max_lat_d;
    logic [7:0]       max_guess_q, max_guess_d;

    cm_byte_filter #(
        .STABLE_CYC (STABLE_CYC)
    ) u_filter (
        .CLK_50    (CLK_50),
        .RST_N     (RST_N),
        .data_in   (data_in),
        .drive_en  (drive_en),
        .tx_done   (tx_done),
        .acc_valid (acc_valid),
        .acc_byte  (acc_byte)
    );

    // Next-state, latency counter and stats; tx_done always restarts the
    // frame, a reply beats a timeout landing in the same cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        guess_d     = guess_q;
        begin_d     = 1'b0;
        valid_d     = 1'b0;
        yes_d       = yes_q;
        latency_d   = latency_q;
        timeout_d   = 1'b0;
        max_lat_d   = max_lat_q;
        max_guess_d = max_guess_q;
        cnt_inc     = (cnt_q == LAT_MAX) ? cnt_q : cnt_q + 1'b1;

        case (state_q)
            RX_IDLE: begin
                if (acc_valid && (acc_byte == CM_BEGIN_GUESSING)) begin
                    begin_d = 1'b1;
                end
                if (tx_done) begin
                    state_d = RX_ARMED;
                    cnt_d   = '0;
                    guess_d = guess_byte;
                end
            end
            RX_ARMED: begin
                if (tx_done) begin
                    cnt_d   = '0;
                    guess_d = guess_byte;
                end else begin
                    cnt_d = cnt_inc;
                    if (acc_valid && is_reply(acc_byte)) begin
                        valid_d   = 1'b1;
                        yes_d     = (acc_byte == CM_YES);
                        latency_d = cnt_inc;
                        state_d   = RX_IDLE;
                    end else if (cnt_inc == TIMEOUT_VAL) begin
                        timeout_d = 1'b1;
                        state_d   = RX_IDLE;
                    end
                end
            end
            default: state_d = RX_IDLE;
        endcase

        // A clear coinciding with a reply restarts the stats from that reply.
        if (valid_d && (clear_stats || (latency_d > max_lat_q))) begin
            max_lat_d   = latency_d;
            max_guess_d = guess_q;
        end else if (clear_stats) begin
            max_lat_d   = '0;
            max_guess_d = 8'h00;
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge CLK_50 or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= RX_IDLE;
            cnt_q       <= '0;
            guess_q     <= 8'h00;
            begin_q     <= 1'b0;
            valid_q     <= 1'b0;
            yes_q       <= 1'b0;
            latency_q   <= '0;
            timeout_q   <= 1'b0;
            max_lat_q   <= '0;
            max_guess_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            guess_q     <= guess_d;
            begin_q     <= begin_d;
            valid_q     <= valid_d;
            yes_q       <= yes_d;
            latency_q   <= latency_d;
            timeout_q   <= timeout_d;
            max_lat_q   <= max_lat_d;
            max_guess_q <= max_guess_d;
        end
    end

    assign begin_pulse = begin_q;
    assign reply_valid = valid_q;
    assign reply_yes   = yes_q;
    assign latency     = latency_q;
    assign timeout     = timeout_q;
    assign max_latency = max_lat_q;
    assign max_guess   = max_guess_q;
    assign busy        = (state_q == RX_ARMED);

endmodule

// File: tb/tb_cm_reply_rx.sv
// Bench for cm_reply_rx: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a window-based model.
module tb_cm_reply_rx;

    localparam int S  = 4;
    localparam int LW = 24;
    localparam int TO = 200;
    localparam int unsigned LMAX = (32'd1 << LW) - 1;

    logic          CLK_50 = 1'b0;
    logic          RST_N = 1'b0;
    logic [7:0]    data_in = 8'h00;
    logic          drive_en = 1'b0;
    logic          tx_done = 1'b0;
    logic [7:0]    guess_byte = 8'h00;
    logic          clear_stats = 1'b0;
    logic          begin_pulse;
    logic          reply_valid;
    logic          reply_yes;
    logic [LW-1:0] latency;
    logic          timeout;
    logic [LW-1:0] max_latency;
    logic [7:0]    max_guess;
    logic          busy;

    cm_reply_rx #(
        .STABLE_CYC  (S),
        .LAT_W       (LW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .CLK_50      (CLK_50),
        .RST_N       (RST_N),
        .data_in     (data_in),
        .drive_en    (drive_en),
        .tx_done     (tx_done),
        .guess_byte  (guess_byte),
        .clear_stats (clear_stats),
        .begin_pulse (begin_pulse),
        .reply_valid (reply_valid),
        .reply_yes   (reply_yes),
        .latency     (latency),
        .timeout     (timeout),
        .max_latency (max_latency),
        .max_guess   (max_guess),
        .busy        (busy)
    );

    always #10 CLK_50 = ~CLK_50;

    int n_vec = 0;
    int n_err = 0;
    bit run_chk = 1'b0;

    // Model: recent synced samples (hist[0] newest) and drive_en history.
    logic [7:0]  hist [0:S+1];
    bit          dh   [0:S-1];
    logic [7:0]  m_last;
    bit          m_armed;
    int unsigned m_cnt;
    logic [7:0]  m_guess;
    bit          m_begin, m_rv, m_yes, m_to;
    int unsigned m_lat, m_maxl;
    logic [7:0]  m_maxg;

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j <= S + 1; j++) hist[j] = 8'h00;
        for (int j = 0; j < S; j++) dh[j] = 1'b1;
        m_last = 8'h00; m_armed = 1'b0; m_cnt = 0; m_guess = 8'h00;
        m_begin = 1'b0; m_rv = 1'b0; m_yes = 1'b0; m_to = 1'b0;
        m_lat = 0; m_maxl = 0; m_maxg = 8'h00;
    endtask

    // One clock edge of the model, using the inputs the DUT samples.
    task automatic model_edge();
        logic [7:0] cand;
        bit stable, acc;
        for (int j = S + 1; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = data_in;
        for (int j = S - 1; j > 0; j--) dh[j] = dh[j-1];
        dh[0] = drive_en;
        // Accept when S identical synced samples were seen with the bus free.
        cand = hist[2];
        stable = 1'b1;
        for (int j = 2; j <= S + 1; j++) if (hist[j] != cand) stable = 1'b0;
        for (int j = 0; j < S; j++) if (dh[j]) stable = 1'b0;
        acc = stable && (cand != m_last);
        if (drive_en || tx_done) m_last = 8'h00;
        else if (acc) m_last = cand;

        m_begin = 1'b0; m_rv = 1'b0; m_to = 1'b0;
        if (!m_armed) begin
            if (acc && cand == 8'h02) m_begin = 1'b1;
            if (tx_done) begin m_armed = 1'b1; m_cnt = 0; m_guess = guess_byte; end
        end else if (tx_done) begin
            m_cnt = 0; m_guess = guess_byte;
        end else begin
            if (m_cnt < LMAX) m_cnt++;
            if (acc && (cand == 8'h03 || cand == 8'h04)) begin
                m_rv = 1'b1; m_yes = (cand == 8'h03); m_lat = m_cnt; m_armed = 1'b0;
                if (clear_stats || m_cnt > m_maxl) begin m_maxl = m_cnt; m_maxg = m_guess; end
            end else if (m_cnt == TO) begin
                m_to = 1'b1; m_armed = 1'b0;
            end
        end
        if (clear_stats && !m_rv) begin m_maxl = 0; m_maxg = 8'h00; end
    endtask

    task automatic tick();
        @(posedge CLK_50);
        if (!RST_N) model_reset(); else model_edge();
        @(negedge CLK_50);
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge CLK_50) begin
        if (run_chk) begin
            chk("begin_pulse", begin_pulse, m_begin);
            chk("reply_valid", reply_valid, m_rv);
            chk("reply_yes",   reply_yes,   m_yes);
            chk("latency",     latency,     m_lat);
            chk("timeout",     timeout,     m_to);
            chk("max_latency", max_latency, m_maxl);
            chk("max_guess",   max_guess,   m_maxg);
            chk("busy",        busy,        m_armed);
        end
    end

    task automatic check_zero(input string pfx);
        chk({pfx, "_begin"},   begin_pulse, 0);
        chk({pfx, "_valid"},   reply_valid, 0);
        chk({pfx, "_yes"},     reply_yes,   0);
        chk({pfx, "_latency"}, latency,     0);
        chk({pfx, "_timeout"}, timeout,     0);
        chk({pfx, "_maxlat"},  max_latency, 0);
        chk({pfx, "_maxg"},    max_guess,   0);
        chk({pfx, "_busy"},    busy,        0);
    endtask

    task automatic wait_reply(input int maxc, output int lat, output bit yes, output bit got);
        got = 1'b0; lat = 0; yes = 1'b0;
        for (int k = 0; k < maxc && !got; k++) begin
            tick();
            if (reply_valid) begin got = 1'b1; lat = int'(latency); yes = reply_yes; end
        end
    endtask

    task automatic bus_release();
        data_in = 8'h00; drive_en = 1'b1;
        tick(); tick();
        drive_en = 1'b0;
        tick();
    endtask

    task automatic send_guess(input logic [7:0] g);
        guess_byte = g; tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    // One guess round answered with NO, s1 capturing it d edges after arm.
    task automatic round(input logic [7:0] g, input int d, output int lat, output bit got);
        bit yes;
        bus_release();
        send_guess(g);
        repeat (d - 1) tick();
        data_in = 8'h04;
        tick();
        wait_reply(20, lat, yes, got);
        chk("round_got", got, 1);
        chk("round_yes", yes, 0);
    endtask

    initial begin
        int first, cnt, lat;
        bit got, yes;
        int hold, de_left;

        model_reset();
        run_chk = 1'b1;
        tick(); tick(); tick();
        check_zero("reset");
        RST_N = 1'b1;
        repeat (3) tick();

        // 0x02 held 10 cycles in IDLE: exactly one begin_pulse, 5 edges after capture.
        data_in = 8'h02;
        first = -1; cnt = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (begin_pulse) begin cnt++; if (first < 0) first = k; end
        end
        chk("begin_count", cnt, 1);
        chk("begin_pos", first, 6);

        // Guess 0x10, NO captured 100 edges after arm: latency 105.
        send_guess(8'h10);
        repeat (99) tick();
        data_in = 8'h04;
        tick();
        wait_reply(20, lat, yes, got);
        chk("b_got", got, 1);
        chk("b_latency", lat, 105);
        chk("b_yes", yes, 0);
        chk("b_max_guess", max_guess, 8'h10);
        chk("b_model_lat", m_lat, 105);

        clear_stats = 1'b1; tick(); clear_stats = 1'b0;
        chk("clr_maxlat", max_latency, 0);
        chk("clr_maxg", max_guess, 0);

        // Consecutive identical NO replies; ties keep the earlier guess.
        round(8'h11, 50, lat, got);
        chk("r1_latency", lat, 55);
        round(8'h12, 80, lat, got);
        chk("r2_latency", lat, 85);
        chk("r2_maxlat", max_latency, 85);
        chk("r2_maxg", max_guess, 8'h12);
        round(8'h13, 80, lat, got);
        chk("r3_latency", lat, 85);
        chk("r3_maxg", max_guess, 8'h12);
        chk("r3_model_maxg", m_maxg, 8'h12);

        // 0x04 glitching to 0x00 two of every three cycles: never accepted.
        bus_release();
        send_guess(8'h30);
        cnt = 0;
        for (int r = 0; r < 10; r++) begin
            data_in = 8'h04; tick(); if (reply_valid) cnt++;
            data_in = 8'h00; tick(); if (reply_valid) cnt++;
            tick(); if (reply_valid) cnt++;
        end
        chk("glitch_replies", cnt, 0);
        data_in = 8'h04;
        first = -1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (reply_valid && first < 0) first = k;
        end
        chk("glitch_accept_pos", first, 6);

        // No reply: timeout 200 edges after arm, stats untouched, late YES ignored.
        bus_release();
        send_guess(8'h40);
        first = -1;
        for (int k = 1; k <= 250 && first < 0; k++) begin
            tick();
            if (timeout) first = k;
        end
        chk("timeout_pos", first, 200);
        chk("timeout_busy", busy, 0);
        chk("timeout_maxlat", max_latency, 85);
        chk("timeout_maxg", max_guess, 8'h12);
        data_in = 8'h03;
        cnt = 0;
        repeat (12) begin tick(); if (reply_valid) cnt++; end
        chk("late_yes", cnt, 0);

        // Reset in ARMED: outputs clear immediately, nothing spurious afterwards.
        bus_release();
        send_guess(8'h50);
        repeat (20) tick();
        chk("pre_rst_busy", busy, 1);
        #2 RST_N = 1'b0;
        #1 check_zero("async_rst");
        tick(); tick();
        RST_N = 1'b1;
        cnt = 0;
        repeat (20) begin tick(); if (begin_pulse || reply_valid || timeout) cnt++; end
        chk("post_rst_pulses", cnt, 0);
        chk("post_rst_busy", busy, 0);

        // Randomized traffic.
        hold = 0; de_left = 0;
        repeat (4000) begin
            if (hold == 0) begin
                int sel;
                sel = $urandom_range(0, 9);
                data_in = (sel <= 6) ? 8'(sel) : 8'($urandom);
                hold = $urandom_range(1, 12);
            end
            hold--;
            if (de_left > 0) begin
                de_left--; drive_en = 1'b1;
            end else begin
                drive_en = 1'b0;
                if ($urandom_range(0, 39) == 0) de_left = $urandom_range(1, 5);
            end
            tx_done = ($urandom_range(0, 59) == 0);
            guess_byte = 8'($urandom);
            clear_stats = ($urandom_range(0, 299) == 0);
            tick();
        end
        tx_done = 1'b0; clear_stats = 1'b0; drive_en = 1'b0;
        tick();
        run_chk = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
